pipelined_adder: RTL and testbench
==================================

# pipelined_adder

Parametrised, pipelined ripple-carry adder/subtractor with a valid/ready handshake on both sides. The datapath splits the operands into equal chunks. Each pipeline stage ripples one chunk and registers the carry into the next stage, so throughput is one operation per cycle at any width. The block serves as the generic wide-add datapath primitive for accumulators and address/counter logic that need more width than a single-cycle ripple can close timing on.

## Interface
- `WIDTH`, default 32: operand and sum width in bits.
- `STAGES`, default 4: number of pipeline stages. `WIDTH % STAGES == 0` is required; elaboration fails otherwise.
- `CHUNK` (localparam): `WIDTH/STAGES`, the bits added per stage.
- `clk` input, 1 bit: the single clock; all state changes on its rising edge.
- `rst_n` input, 1 bit: asynchronous, active-low reset.
- `in_valid` input, 1 bit: operand set presented.
- `in_ready` output, 1 bit: stage 0 can accept this cycle.
- `in_a`, `in_b` input, WIDTH bits: operands.
- `in_cin` input, 1 bit: carry-in for add, borrow-in for subtract.
- `in_sub` input, 1 bit: 0 = add, 1 = subtract.
- `out_valid` output, 1 bit: result held in the final stage.
- `out_ready` input, 1 bit: downstream accepts the result.
- `out_sum` output, WIDTH bits: result.
- `out_cout` output, 1 bit: raw carry out of the MSB. For subtract, 1 means no borrow.
- `out_ovf` output, 1 bit: two's-complement signed overflow.

## Operation
- Add: sum = a + b + in_cin.
- Subtract: sum = a + ~b + ~in_cin, which equals a − b − in_cin.
- The effective operand is `b ^ {WIDTH{in_sub}}` and the effective carry-in is `in_cin ^ in_sub`.
- Both are formed at acceptance and captured into stage 0.
- Stage k (0-based) adds bits [k·CHUNK +: CHUNK] using the carry registered by stage k−1; stage 0 uses the effective carry-in.
- Operand bits above chunk k travel skewed with the pipeline. Completed sum bits below chunk k travel delayed alongside them.
- Each stage registers: its valid bit, its partial sum, the remaining operand bits, its chunk carry-out and the opcode.
- `out_cout` is the carry out of stage STAGES−1.
- `out_ovf` = carry into MSB XOR carry out of MSB, computed within the final chunk.
- Transaction order is preserved; no reordering, dropping or duplication.

## Timing
- Reset (asynchronous, immediate on `rst_n` low):
  - all stage valid bits = 0, so `out_valid` = 0;
  - `out_sum`, `out_cout`, `out_ovf` = 0;
  - all data registers = 0;
  - `in_ready` = 1 while `rst_n` is high and the pipe is empty.
- Accept: a transfer occurs on a rising edge with `in_valid && in_ready`.
- Latency: a result accepted on edge N is presented with `out_valid` = 1 after edge N+STAGES−1, i.e. STAGES registers from input to output.
- Advance rule:
  - stage i loads from stage i−1 when stage i is empty, or stage i is being drained that cycle;
  - the final stage drains when `out_valid && out_ready`;
  - `in_ready` = stage 0 empty or stage 0 advancing.
- The combinational path `out_ready` → `in_ready` through STAGES enable terms is permitted.
- Bubbles collapse: an empty stage always accepts from its predecessor, even while the output is stalled.
- Capacity: STAGES transactions. With `out_ready` held low and the pipe full, `in_ready` = 0.
- Stall hold: while `out_valid && !out_ready`, `out_sum`, `out_cout` and `out_ovf` must not change.
- Simultaneous drain and accept in the same cycle at full occupancy: both occur; throughput stays 1 per cycle.
- Reset mid-operation: in-flight transactions are discarded and nothing is emitted after `rst_n` rises.
- `in_*` inputs are don't-care when `in_valid` = 0. `out_*` data is don't-care when `out_valid` = 0, but holds its last value.

## Structure
- Shared package `adder_pkg` holds:
  - the opcode enum `op_e` {`OP_ADD`=0, `OP_SUB`=1};
  - the default width/stage constants;
  - a function `stage_ok(width, stages)` used in the elaboration check.
- One sub-module, `ripple_chunk`:
  - parameter `N`;
  - inputs `a[N]`, `b[N]`, `cin`;
  - outputs `sum[N]`, `cout`, plus `c_msb_in` for overflow;
  - purely combinational: a chain of one-bit full-adder cells using carry = cin·(a⊕b) + a·b;
  - instantiated STAGES times via generate.

## Test plan
1. **Wrap-around add:** WIDTH=32, STAGES=4; add 0xFFFF_FFFF + 0x1, cin=0 → sum 0x0000_0000, cout=1, ovf=0; `out_valid` rises exactly 4 edges after acceptance.
2. **Signed overflow add:** 0x7FFF_FFFF + 0x1 → sum 0x8000_0000, cout=0, ovf=1.
3. **Subtract, borrow case:** 5 − 7, cin=0 → 0xFFFF_FFFE, cout=0, ovf=0.
4. **Subtract, overflow case:** 0x8000_0000 − 1 → 0x7FFF_FFFF, cout=1, ovf=1.
5. **Streaming:** 8 back-to-back transactions with `out_ready`=1 and operands a=i, b=i·3 → 8 results 4i on consecutive cycles, in order, `in_ready` constantly 1.
6. **Backpressure:** `out_ready`=0 for 6 cycles while offering 6 transactions → exactly 4 accepted, `in_ready`=0 afterwards, output held stable; after release all 6 emerge in order with no loss or duplicate.
7. **Reset mid-operation:** `rst_n` low with 3 in flight → `out_valid` and outputs go to 0 without waiting for a clock edge; after release no stale result appears and the next transaction has normal 4-cycle latency.

Source files
------------

// File: rtl/adder_pkg.sv
// rtl/adder_pkg.sv - shared opcode type, default sizing and parameter check for pipelined_adder
package adder_pkg;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_e;

  localparam int DEF_WIDTH  = 32;
  localparam int DEF_STAGES = 4;

  // The operands must split into STAGES equal, non-empty chunks.
  function automatic bit stage_ok(input int width, input int stages);
    return (stages > 0) && (width >= stages) && ((width % stages) == 0);
  endfunction

endpackage

// File: rtl/ripple_chunk.sv
// rtl/ripple_chunk.sv - combinational N-bit ripple-carry slice used by each pipeline stage
//   a, b      : chunk operands (b already inverted for subtract)
//   cin       : carry into bit 0
//   sum       : chunk sum
//   cout      : carry out of bit N-1
//   c_msb_in  : carry into bit N-1, used for signed overflow in the top chunk
module ripple_chunk
  import adder_pkg::*;
#(
  parameter int N = 8
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] sum,
  output logic         cout,
  output logic         c_msb_in
);

  logic carry;

  // One full-adder cell per bit; carry walks upward through the loop.
  always_comb begin
    sum      = '0;
    carry    = cin;
    c_msb_in = cin;
    for (int i = 0; i < N; i++) begin
      c_msb_in = carry;
      sum[i]   = a[i] ^ b[i] ^ carry;
      carry    = (carry & (a[i] ^ b[i])) | (a[i] & b[i]);
    end
    cout = carry;
  end

endmodule

// File: rtl/pipelined_adder.sv
// rtl/pipelined_adder.sv - pipelined ripple-carry adder/subtractor with valid/ready on both sides
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid/in_ready   : operand handshake
//   in_a, in_b          : operands
//   in_cin              : carry-in (add) / borrow-in (subtract)
//   in_sub              : 0 = add, 1 = subtract
//   out_valid/out_ready : result handshake
//   out_sum             : result
//   out_cout            : carry out of MSB (subtract: 1 = no borrow)
//   out_ovf             : two's-complement overflow
module pipelined_adder
  import adder_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int STAGES = DEF_STAGES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf
);

  localparam int CHUNK = WIDTH / STAGES;

  if (!stage_ok(WIDTH, STAGES)) begin : g_bad_params
    $error("pipelined_adder: WIDTH must be a non-zero multiple of STAGES");
  end

  logic [STAGES-1:0] vld;
  logic [STAGES-1:0] take;   // stage can capture this cycle
  logic [STAGES-1:0] ld;     // stage captures a real transaction this cycle
  logic              free;

  logic [WIDTH-1:0]  s_a   [STAGES];
  logic [WIDTH-1:0]  s_b   [STAGES];
  logic [WIDTH-1:0]  s_sum [STAGES];
  logic              s_c   [STAGES];
  op_e               s_op  [STAGES];
  logic              ovf_q;

  logic [CHUNK-1:0]  ca    [STAGES];
  logic [CHUNK-1:0]  cb    [STAGES];
  logic [CHUNK-1:0]  cs    [STAGES];
  logic              cci   [STAGES];
  logic              cco   [STAGES];
  logic              cmsb  [STAGES];
  logic [WIDTH-1:0]  nsum  [STAGES];
  logic [WIDTH-1:0]  b_eff;

  assign b_eff = in_b ^ {WIDTH{in_sub}};

  // Walk from the output back to the input: a stage can take new data when
  // it is empty or when its own content moves on this cycle. This lets
  // bubbles collapse even while the output is stalled.
  always_comb begin
    take = '0;
    ld   = '0;
    free = out_ready;
    for (int k = STAGES - 1; k >= 0; k--) begin
      take[k] = !vld[k] || free;
      free    = take[k];
    end
    ld[0] = take[0] && in_valid;
    for (int k = 1; k < STAGES; k++) begin
      ld[k] = take[k] && vld[k-1];
    end
  end

  // Stage 0 adds straight from the inputs; later stages add their chunk of
  // the skewed operands with the carry registered by the previous stage.
  always_comb begin
    ca[0]  = in_a[CHUNK-1:0];
    cb[0]  = b_eff[CHUNK-1:0];
    cci[0] = in_cin ^ in_sub;
    for (int k = 1; k < STAGES; k++) begin
      ca[k]  = s_a[k-1][k*CHUNK +: CHUNK];
      cb[k]  = s_b[k-1][k*CHUNK +: CHUNK];
      cci[k] = s_c[k-1];
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_chunk
    ripple_chunk #(.N(CHUNK)) u_chunk (
      .a        (ca[k]),
      .b        (cb[k]),
      .cin      (cci[k]),
      .sum      (cs[k]),
      .cout     (cco[k]),
      .c_msb_in (cmsb[k])
    );
  end

  // Completed low chunks ride along; each stage drops in its own chunk.
  always_comb begin
    nsum[0]            = '0;
    nsum[0][CHUNK-1:0] = cs[0];
    for (int k = 1; k < STAGES; k++) begin
      nsum[k]                    = s_sum[k-1];
      nsum[k][k*CHUNK +: CHUNK]  = cs[k];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld   <= '0;
      ovf_q <= 1'b0;
      for (int k = 0; k < STAGES; k++) begin
        s_a[k]   <= '0;
        s_b[k]   <= '0;
        s_sum[k] <= '0;
        s_c[k]   <= 1'b0;
        s_op[k]  <= OP_ADD;
      end
    end else begin
      if (take[0]) begin
        vld[0] <= in_valid;
      end
      if (ld[0]) begin
        s_a[0]   <= in_a;
        s_b[0]   <= b_eff;
        s_sum[0] <= nsum[0];
        s_c[0]   <= cco[0];
        s_op[0]  <= op_e'(in_sub);
      end
      for (int k = 1; k < STAGES; k++) begin
        if (take[k]) begin
          vld[k] <= vld[k-1];
        end
        if (ld[k]) begin
          s_a[k]   <= s_a[k-1];
          s_b[k]   <= s_b[k-1];
          s_sum[k] <= nsum[k];
          s_c[k]   <= cco[k];
          s_op[k]  <= s_op[k-1];
        end
      end
      // Overflow only makes sense once the top chunk has been added.
      if (ld[STAGES-1]) begin
        ovf_q <= cmsb[STAGES-1] ^ cco[STAGES-1];
      end
    end
  end

  assign in_ready  = take[0];
  assign out_valid = vld[STAGES-1];
  assign out_sum   = s_sum[STAGES-1];
  assign out_cout  = s_c[STAGES-1];
  assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_pipelined_adder.sv
// tb/tb_pipelined_adder.sv - self-checking bench for pipelined_adder (WIDTH=32, STAGES=4)
module tb_pipelined_adder;

  localparam int W = 32;
  localparam int S = 4;
  localparam longint SMAX = 64'sd2147483647;
  localparam longint SMIN = -64'sd2147483648;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_a = '0;
  logic [W-1:0] in_b = '0;
  logic         in_cin = 1'b0;
  logic         in_sub = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_sum;
  logic         out_cout;
  logic         out_ovf;

  int total = 0;
  int bad = 0;
  logic [33:0] expq[$];

  always #5 clk = ~clk;

  pipelined_adder #(.WIDTH(W), .STAGES(S)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_cin    (in_cin),
    .in_sub    (in_sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout),
    .out_ovf   (out_ovf)
  );

  // Reference: plain unsigned/signed integer arithmetic. Returns {cout, ovf, sum}.
  function automatic logic [33:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                        input logic cin, input logic sub);
    longint ua, ub, sa, sb, ur, sr;
    logic co, ov;
    ua = longint'({32'b0, a});
    ub = longint'({32'b0, b});
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (sub) begin
      ur = ua - ub - longint'(cin);
      sr = sa - sb - longint'(cin);
      co = (ua >= ub + longint'(cin));
    end else begin
      ur = ua + ub + longint'(cin);
      sr = sa + sb + longint'(cin);
      co = (ur > 64'sd4294967295);
    end
    ov = (sr > SMAX) || (sr < SMIN);
    return {co, ov, ur[31:0]};
  endfunction

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  // Scoreboard: every accepted operand set must come out once, in order.
  always @(negedge clk) begin
    if (!rst_n) begin
      expq.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (expq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL scoreboard_extra: got %h with nothing outstanding", out_sum);
        end else begin
          chk("scoreboard", {30'b0, out_cout, out_ovf, out_sum}, {30'b0, expq.pop_front()});
        end
      end
      if (in_valid && in_ready) expq.push_back(model(in_a, in_b, in_cin, in_sub));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin, input logic sub);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_cin   = cin;
    in_sub   = sub;
  endtask

  task automatic apply_vec(input vec_t v, input string tag);
    int n;
    drive(v.a, v.b, v.cin, v.sub);
    chk({tag, "_in_ready"}, in_ready, 1);
    tick();
    in_valid = 1'b0;
    chk({tag, "_early"}, out_valid, 0);
    n = 0;
    while (!out_valid && n < 10) begin
      tick();
      n++;
    end
    chk({tag, "_latency"}, n, S - 1);
    chk({tag, "_result"}, {out_cout, out_ovf, out_sum}, {v.cout, v.ovf, v.sum});
    tick();
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    vec_t vt[7];
    logic [W-1:0] got[6];
    logic [33:0] held;
    int k, gap, first_c, next, cnt, extra, stale, n;
    logic rdy;

    vt[0] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
    vt[1] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1};
    vt[2] = '{32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0};
    vt[3] = '{32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1};
    vt[4] = '{32'h0000_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h0001_0000, 1'b0, 1'b0};
    vt[5] = '{32'h0000_000A, 32'h0000_0003, 1'b1, 1'b1, 32'h0000_0006, 1'b1, 1'b0};
    vt[6] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1};

    // Reset state
    tick();
    tick();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_sum", out_sum, 0);
    chk("rst_out_cout", out_cout, 0);
    chk("rst_out_ovf", out_ovf, 0);
    rst_n = 1'b1;
    out_ready = 1'b1;
    #1;
    chk("rst_in_ready", in_ready, 1);
    tick();

    // Directed vectors, one at a time, with latency
    for (int i = 0; i < 7; i++) apply_vec(vt[i], $sformatf("vec%0d", i));

    // Streaming: a=i, b=3i back to back
    k = 0; gap = 0; first_c = -1;
    for (int c = 0; c < 14; c++) begin
      if (c < 8) begin
        drive(c, 3 * c, 1'b0, 1'b0);
        chk("stream_in_ready", in_ready, 1);
      end else begin
        in_valid = 1'b0;
      end
      if (out_valid) begin
        if (first_c < 0) first_c = c;
        if (k < 8) chk("stream_sum", out_sum, 4 * k);
        k++;
      end else if (k > 0 && k < 8) begin
        gap++;
      end
      tick();
    end
    chk("stream_count", k, 8);
    chk("stream_gap", gap, 0);
    chk("stream_first", first_c, S);

    // Backpressure: offer 6 with output stalled
    out_ready = 1'b0;
    next = 0;
    held = '0;
    for (int c = 0; c < 6; c++) begin
      drive(100 + next, next, 1'b0, 1'b0);
      #1;
      rdy = in_ready;
      if (c == 4) begin
        chk("bp_out_valid", out_valid, 1);
        held = {out_cout, out_ovf, out_sum};
        chk("bp_head", out_sum, 100);
      end
      @(posedge clk);
      if (rdy) next++;
      #1;
    end
    chk("bp_accepted", next, 4);
    chk("bp_in_ready_full", in_ready, 0);
    for (int c = 0; c < 3; c++) begin
      chk("bp_hold", {out_cout, out_ovf, out_sum}, held);
      tick();
    end
    out_ready = 1'b1;
    cnt = 0; extra = 0;
    for (int c = 0; c < 20; c++) begin
      if (next < 6) drive(100 + next, next, 1'b0, 1'b0);
      else in_valid = 1'b0;
      if (out_valid) begin
        if (cnt < 6) got[cnt] = out_sum;
        else extra++;
        cnt++;
      end
      #1;
      rdy = in_ready;
      @(posedge clk);
      if (rdy && next < 6) next++;
      #1;
    end
    chk("bp_count", cnt, 6);
    chk("bp_extra", extra, 0);
    for (int j = 0; j < 6; j++) chk($sformatf("bp_order%0d", j), got[j], 100 + 2 * j);

    // Reset with transactions in flight
    out_ready = 1'b0;
    drive(32'hC000_0000, 32'h8000_0000, 1'b0, 1'b0);
    tick();
    drive(32'h1, 32'h2, 1'b0, 1'b0);
    tick();
    drive(32'h3, 32'h4, 1'b0, 1'b1);
    tick();
    in_valid = 1'b0;
    tick();
    chk("mid_valid", out_valid, 1);
    chk("mid_result", {out_cout, out_ovf, out_sum}, {1'b1, 1'b1, 32'h4000_0000});
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", out_valid, 0);
    chk("async_rst_sum", out_sum, 0);
    chk("async_rst_cout", out_cout, 0);
    chk("async_rst_ovf", out_ovf, 0);
    tick();
    tick();
    rst_n = 1'b1;
    out_ready = 1'b1;
    #1;
    chk("post_rst_in_ready", in_ready, 1);
    stale = 0;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (out_valid) stale++;
    end
    chk("post_rst_stale", stale, 0);
    apply_vec(vt[0], "post_rst");

    // Random traffic against the scoreboard
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 3) != 0) drive(pick(), pick(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      else in_valid = 1'b0;
      out_ready = ($urandom_range(0, 2) != 0);
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    n = 0;
    while (expq.size() != 0 && n < 50) begin
      tick();
      n++;
    end
    chk("drain_empty", expq.size(), 0);
    tick();
    chk("drain_out_valid", out_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
